// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   PC register plus IF/DEC pipeline latch for a 5-stage pipeline. Issues
//   instruction fetches to the icache and holds, bubbles or redirects the
//   fetch stream under the stall / flush / ihit controls. The rs/rt selects
//   of the instruction in decode go straight to the hazard unit.
//
// Parameters
//   PC_INIT      PC loaded on reset (word aligned)
//
// Ports
//   CLK          clock, all state updates on the rising edge
//   RST          synchronous, active-high reset
//   ihit         icache: imemload valid for imemaddr this cycle
//   imemload     icache read data
//   imemREN      icache read enable (low only while halted)
//   imemaddr     icache address, always word aligned
//   stall        hazard unit: hold PC and DEC latch
//   flush        branch/jump resolved in EX: squash DEC, redirect PC
//   redirect_pc  redirect target, used when flush=1 (low two bits ignored)
//   instr_dec    instruction in decode
//   npc_dec      PC+4 of instr_dec
//   valid_dec    instr_dec is a real instruction (0 = bubble)
//   rsel1_dec    instr_dec[25:21] when valid_dec, else 0
//   rsel2_dec    instr_dec[20:16] when valid_dec, else 0
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr_dec,
  output logic [31:0] npc_dec,
  output logic        valid_dec,
  output logic [4:0]  rsel1_dec,
  output logic [4:0]  rsel2_dec
);

  // FETCH   : normal fetch stream
  // DISCARD : a miss at the old PC is still in flight after a flush; wait
  //           for it to complete, drop its data, then jump to target_q
  // HALTED  : halt instruction reached decode; fetching stops
  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    DISCARD = 2'd1,
    HALTED  = 2'd2
  } state_e;

  localparam logic [5:0]  HALT_OP  = 6'h3F;
  localparam logic [31:0] PC_RESET = {PC_INIT[31:2], 2'b00};

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] target_q, target_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] npc_q, npc_d;
  logic        valid_q, valid_d;

  logic [31:0] pc_plus4;
  logic [31:0] redirect_aligned;
  logic        halt_in_dec;
  logic        unused_redirect_lsbs;

  assign pc_plus4             = pc_q + 32'd4;  // wraps modulo 2^32
  assign redirect_aligned     = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign halt_in_dec          = valid_q && (instr_q[31:26] == HALT_OP);

  // ---------------------------------------------------------------------------
  // State register (FSM state and datapath registers)
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its inputs, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= FETCH;
      pc_q     <= PC_RESET;
      target_q <= '0;
      instr_q  <= '0;
      npc_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      target_q <= target_d;
      instr_q  <= instr_d;
      npc_q    <= npc_d;
      valid_q  <= valid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. Priority everywhere: flush > stall > ihit.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH: begin
        if (flush)            state_d = ihit ? FETCH : DISCARD;
        else if (halt_in_dec) state_d = HALTED;
      end
      DISCARD: begin
        if (ihit) state_d = FETCH;
      end
      HALTED: begin
        if (flush) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath next values (PC, pending target, DEC latch)
  // ---------------------------------------------------------------------------
  // NOTE: every signal gets a hold default before the case so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    pc_d     = pc_q;
    target_d = target_q;
    instr_d  = instr_q;
    npc_d    = npc_q;
    valid_d  = valid_q;

    unique case (state_q)
      FETCH: begin
        if (flush) begin
          // Squash decode; if the current fetch is still missing, its
          // response must be absorbed before the redirect can take effect.
          instr_d = '0;
          valid_d = 1'b0;
          if (ihit) pc_d     = redirect_aligned;
          else      target_d = redirect_aligned;
        end else if (halt_in_dec || stall) begin
          // Hold everything; any word arriving now is refetched later.
        end else if (ihit) begin
          instr_d = imemload;
          npc_d   = pc_plus4;
          valid_d = 1'b1;
          pc_d    = pc_plus4;
        end else begin
          instr_d = '0;
          valid_d = 1'b0;
        end
      end

      DISCARD: begin
        instr_d = '0;
        valid_d = 1'b0;
        if (ihit)       pc_d     = flush ? redirect_aligned : target_q;
        else if (flush) target_d = redirect_aligned;  // latest redirect wins
      end

      HALTED: begin
        if (flush) begin
          pc_d    = redirect_aligned;
          instr_d = '0;
          valid_d = 1'b0;
        end
      end

      default: begin
        pc_d    = pc_q;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    imemREN   = (state_q != HALTED);
    imemaddr  = {pc_q[31:2], 2'b00};
    instr_dec = instr_q;
    npc_dec   = npc_q;
    valid_dec = valid_q;
    rsel1_dec = valid_q ? instr_q[25:21] : 5'd0;
    rsel2_dec = valid_q ? instr_q[20:16] : 5'd0;
  end

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//   Directed, table-driven bench for fetch_stage. A second instance with
//   PC_INIT = 0xFFFF_FFFC shares the stimulus and covers PC wrap-around and
//   reset out of DISCARD.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ihit;
  logic [31:0] imemload;
  logic        stall;
  logic        flush;
  logic [31:0] redirect_pc;

  logic        ren0, ren1;
  logic [31:0] addr0, addr1;
  logic [31:0] instr0, instr1;
  logic [31:0] npc0, npc1;
  logic        valid0, valid1;
  logic [4:0]  rs0, rs1, rt0, rt1;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  fetch_stage #(.PC_INIT(32'h0000_0000)) dut0 (
    .CLK(CLK), .RST(RST), .ihit(ihit), .imemload(imemload),
    .imemREN(ren0), .imemaddr(addr0), .stall(stall), .flush(flush),
    .redirect_pc(redirect_pc), .instr_dec(instr0), .npc_dec(npc0),
    .valid_dec(valid0), .rsel1_dec(rs0), .rsel2_dec(rt0)
  );

  fetch_stage #(.PC_INIT(32'hFFFF_FFFC)) dut1 (
    .CLK(CLK), .RST(RST), .ihit(ihit), .imemload(imemload),
    .imemREN(ren1), .imemaddr(addr1), .stall(stall), .flush(flush),
    .redirect_pc(redirect_pc), .instr_dec(instr1), .npc_dec(npc1),
    .valid_dec(valid1), .rsel1_dec(rs1), .rsel2_dec(rt1)
  );

  typedef struct {
    logic        rst;
    logic        ihit;
    logic [31:0] load;
    logic        stall;
    logic        flush;
    logic [31:0] redir;
    logic        e_ren;
    logic [31:0] e_addr;
    logic [31:0] e_instr;
    logic [31:0] e_npc;
    logic        e_valid;
    logic [4:0]  e_rs;
    logic [4:0]  e_rt;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic ih, input logic [31:0] ld,
                     input logic st, input logic fl, input logic [31:0] rd,
                     input logic ren, input logic [31:0] addr,
                     input logic [31:0] ins, input logic [31:0] npc,
                     input logic vld, input logic [4:0] rs, input logic [4:0] rt);
    vec_t v;
    v.rst = rst; v.ihit = ih; v.load = ld; v.stall = st; v.flush = fl; v.redir = rd;
    v.e_ren = ren; v.e_addr = addr; v.e_instr = ins; v.e_npc = npc;
    v.e_valid = vld; v.e_rs = rs; v.e_rt = rt;
    vq.push_back(v);
  endtask

  // Drive one cycle of inputs, clock it, sample 1 ns after the edge.
  task automatic step(input logic rst, input logic ih, input logic [31:0] ld,
                      input logic st, input logic fl, input logic [31:0] rd);
    RST = rst; ihit = ih; imemload = ld; stall = st; flush = fl; redirect_pc = rd;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1; ihit = 1'b0; imemload = '0; stall = 1'b0; flush = 1'b0; redirect_pc = '0;

    //   rst ih  load          st fl redirect       ren addr          instr         npc           v  rs     rt
    // Reset state
    add(1, 0, 32'h0,          0, 0, 32'h0,     1, 32'h000, 32'h0,         32'h000, 0, 5'd0,  5'd0);
    // Straight-line fetch, DEC lags one cycle
    add(0, 1, 32'h2001_0001,  0, 0, 32'h0,     1, 32'h004, 32'h2001_0001, 32'h004, 1, 5'd0,  5'd1);
    add(0, 1, 32'h2002_0002,  0, 0, 32'h0,     1, 32'h008, 32'h2002_0002, 32'h008, 1, 5'd0,  5'd2);
    // lw in decode, then two stalled cycles with ihit data ignored
    add(0, 1, 32'h8C22_0004,  0, 0, 32'h0,     1, 32'h00C, 32'h8C22_0004, 32'h00C, 1, 5'd1,  5'd2);
    add(0, 1, 32'hDEAD_BEEF,  1, 0, 32'h0,     1, 32'h00C, 32'h8C22_0004, 32'h00C, 1, 5'd1,  5'd2);
    add(0, 1, 32'hDEAD_BEEF,  1, 0, 32'h0,     1, 32'h00C, 32'h8C22_0004, 32'h00C, 1, 5'd1,  5'd2);
    add(0, 1, 32'h2003_0003,  0, 0, 32'h0,     1, 32'h010, 32'h2003_0003, 32'h010, 1, 5'd0,  5'd3);
    // Flush with hit, misaligned target
    add(0, 1, 32'h1234_5678,  0, 1, 32'h103,   1, 32'h100, 32'h0,         32'h010, 0, 5'd0,  5'd0);
    add(0, 1, 32'h2004_0004,  0, 0, 32'h0,     1, 32'h104, 32'h2004_0004, 32'h104, 1, 5'd0,  5'd4);
    // Miss -> bubble
    add(0, 0, 32'h2222_2222,  0, 0, 32'h0,     1, 32'h104, 32'h0,         32'h104, 0, 5'd0,  5'd0);
    // Flush to 0x8, then flush on a miss -> DISCARD, second flush wins
    add(0, 1, 32'h3333_3333,  0, 1, 32'h008,   1, 32'h008, 32'h0,         32'h104, 0, 5'd0,  5'd0);
    add(0, 0, 32'h0,          0, 1, 32'h200,   1, 32'h008, 32'h0,         32'h104, 0, 5'd0,  5'd0);
    add(0, 0, 32'h0,          0, 0, 32'h0,     1, 32'h008, 32'h0,         32'h104, 0, 5'd0,  5'd0);
    add(0, 0, 32'h0,          0, 1, 32'h300,   1, 32'h008, 32'h0,         32'h104, 0, 5'd0,  5'd0);
    add(0, 0, 32'h0,          1, 0, 32'h0,     1, 32'h008, 32'h0,         32'h104, 0, 5'd0,  5'd0);
    add(0, 1, 32'h4444_4444,  1, 0, 32'h0,     1, 32'h300, 32'h0,         32'h104, 0, 5'd0,  5'd0);
    add(0, 1, 32'h2005_0005,  0, 0, 32'h0,     1, 32'h304, 32'h2005_0005, 32'h304, 1, 5'd0,  5'd5);
    // DISCARD exit with flush+ihit same cycle -> redirect_pc used
    add(0, 0, 32'h0,          0, 1, 32'h400,   1, 32'h304, 32'h0,         32'h304, 0, 5'd0,  5'd0);
    add(0, 1, 32'h5555_5555,  0, 1, 32'h500,   1, 32'h500, 32'h0,         32'h304, 0, 5'd0,  5'd0);
    // Halt latched, then HALTED holds, flush leaves
    add(0, 1, 32'hFFFF_FFFF,  0, 0, 32'h0,     1, 32'h504, 32'hFFFF_FFFF, 32'h504, 1, 5'h1F, 5'h1F);
    add(0, 1, 32'h2006_0006,  0, 0, 32'h0,     0, 32'h504, 32'hFFFF_FFFF, 32'h504, 1, 5'h1F, 5'h1F);
    add(0, 1, 32'h2006_0006,  0, 0, 32'h0,     0, 32'h504, 32'hFFFF_FFFF, 32'h504, 1, 5'h1F, 5'h1F);
    add(0, 0, 32'h0,          0, 1, 32'h600,   1, 32'h600, 32'h0,         32'h504, 0, 5'd0,  5'd0);
    // Halt squashed by flush+stall in FETCH
    add(0, 1, 32'hFFFF_FFFF,  0, 0, 32'h0,     1, 32'h604, 32'hFFFF_FFFF, 32'h604, 1, 5'h1F, 5'h1F);
    add(0, 1, 32'h6666_6666,  1, 1, 32'h700,   1, 32'h700, 32'h0,         32'h604, 0, 5'd0,  5'd0);
    add(0, 1, 32'h2007_0007,  0, 0, 32'h0,     1, 32'h704, 32'h2007_0007, 32'h704, 1, 5'd0,  5'd7);
    // Reset while in DISCARD with a pending target and stall/flush high
    add(0, 0, 32'h0,          0, 1, 32'h800,   1, 32'h704, 32'h0,         32'h704, 0, 5'd0,  5'd0);
    add(1, 0, 32'h0,          1, 1, 32'h900,   1, 32'h000, 32'h0,         32'h000, 0, 5'd0,  5'd0);
    add(0, 1, 32'h2008_0008,  0, 0, 32'h0,     1, 32'h004, 32'h2008_0008, 32'h004, 1, 5'd0,  5'd8);

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].rst, vq[i].ihit, vq[i].load, vq[i].stall, vq[i].flush, vq[i].redir);
      check($sformatf("v%0d.ren",   i), {31'd0, ren0},   {31'd0, vq[i].e_ren});
      check($sformatf("v%0d.addr",  i), addr0,            vq[i].e_addr);
      check($sformatf("v%0d.instr", i), instr0,           vq[i].e_instr);
      check($sformatf("v%0d.npc",   i), npc0,             vq[i].e_npc);
      check($sformatf("v%0d.valid", i), {31'd0, valid0}, {31'd0, vq[i].e_valid});
      check($sformatf("v%0d.rsel1", i), {27'd0, rs0},    {27'd0, vq[i].e_rs});
      check($sformatf("v%0d.rsel2", i), {27'd0, rt0},    {27'd0, vq[i].e_rt});
    end

    // PC wrap-around on the PC_INIT = 0xFFFF_FFFC instance
    step(1, 0, 32'h0, 0, 0, 32'h0);
    check("wrap.reset_addr", addr1, 32'hFFFF_FFFC);
    check("wrap.reset_valid", {31'd0, valid1}, 32'd0);
    step(0, 1, 32'h2009_0009, 0, 0, 32'h0);
    check("wrap.npc",   npc1,   32'h0000_0000);
    check("wrap.addr",  addr1,  32'h0000_0000);
    check("wrap.instr", instr1, 32'h2009_0009);
    check("wrap.valid", {31'd0, valid1}, 32'd1);

    // Reset from DISCARD returns to PC_INIT and FETCH
    step(0, 0, 32'h0, 0, 1, 32'h0000_0A00);
    check("disc.addr_held", addr1, 32'h0000_0000);
    step(0, 0, 32'h0, 1, 0, 32'h0);
    check("disc.valid", {31'd0, valid1}, 32'd0);
    step(1, 0, 32'h0, 0, 0, 32'h0);
    check("disc.rst_addr", addr1, 32'hFFFF_FFFC);
    check("disc.rst_ren", {31'd0, ren1}, 32'd1);
    step(0, 1, 32'h200A_000A, 0, 0, 32'h0);
    check("disc.rst_fetch_instr", instr1, 32'h200A_000A);
    check("disc.rst_fetch_valid", {31'd0, valid1}, 32'd1);
    check("disc.rst_fetch_addr", addr1, 32'h0000_0000);
    check("disc.rst_fetch_rsel2", {27'd0, rt1}, 32'd10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
